// File: rtl/sram_clr_if.sv
// sram_clr_if -- request/response bus of the self-clearing SRAM.
//
// Signals (names follow the SRAM macro pin names):
//   CEN  chip enable, active-low          (master -> slave)
//   WEN  1 = read, 0 = write              (master -> slave)
//   A    word address                     (master -> slave)
//   D    write data                       (master -> slave)
//   M    byte write mask, active-high     (master -> slave)
//   Q    registered read data             (slave -> master)
//   QV   read-data valid pulse            (slave -> master)
//   RDY  initial clear done, bus accepted (slave -> master)
interface sram_clr_if #(
  parameter int WIDTH     = 128,
  parameter int ADD_WIDTH = 11
) ();
  logic                   CEN;
  logic                   WEN;
  logic [ADD_WIDTH-1:0]   A;
  logic [WIDTH-1:0]       D;
  logic [WIDTH/8-1:0]     M;
  logic [WIDTH-1:0]       Q;
  logic                   QV;
  logic                   RDY;

  modport master (
    output CEN, WEN, A, D, M,
    input  Q, QV, RDY
  );

  modport slave (
    input  CEN, WEN, A, D, M,
    output Q, QV, RDY
  );
endinterface

// File: rtl/sram_clr.sv
// sram_clr -- single-port SRAM that zeroes itself after reset.
//
// After RESET the block sweeps every word to zero (SIZE cycles, RDY=0),
// then serves byte-masked writes and latency-1 reads (RDY=1).
//
// Ports:
//   CLK    single clock, rising edge
//   RESET  synchronous, active-high; restarts the clear sweep
//   bus    sram_clr_if.slave (CEN, WEN, A, D, M in; Q, QV, RDY out)
//
// Optional feature macro: SRAM_CLR_OUTREG_EN
//   defined   -> one extra output register after Q/QV (read latency 2)
//   undefined -> read latency 1
module sram_clr #(
  parameter int SIZE      = 2048,
  parameter int WIDTH     = 128,
  parameter int ADD_WIDTH = 11
) (
  input  logic       CLK,
  input  logic       RESET,
  sram_clr_if.slave  bus
);

  localparam int                   NBYTES  = WIDTH / 8;
  localparam logic [ADD_WIDTH-1:0] LP_LAST = ADD_WIDTH'(SIZE - 1);

  typedef enum logic [0:0] {
    S_CLEAR = 1'b0,
    S_IDLE  = 1'b1
  } state_t;

  state_t               r_state;
  logic [ADD_WIDTH-1:0] r_cnt;
  logic [WIDTH-1:0]     r_q;
  logic                 r_qv;
  logic                 r_rdy;
  logic [WIDTH-1:0]     r_mem [SIZE];

  logic w_addr_ok;
  logic w_req;
  logic w_wr;
  logic w_rd;

  // When the address space is exactly SIZE every address is legal, so the
  // range compare is dropped instead of leaving an always-true comparison.
  generate
    if (SIZE >= (2 ** ADD_WIDTH)) begin : g_full_range
      assign w_addr_ok = 1'b1;
    end else begin : g_part_range
      assign w_addr_ok = ({1'b0, bus.A} < (ADD_WIDTH + 1)'(SIZE));
    end
  endgenerate

  // Requests only count in IDLE; a simultaneous RESET wins.
  assign w_req = (r_state == S_IDLE) && !bus.CEN && !RESET;
  assign w_wr  = w_req && !bus.WEN && w_addr_ok;
  assign w_rd  = w_req && bus.WEN;

  // Control FSM: clear sweep, ready flag and registered read port.
  always_ff @(posedge CLK) begin
    if (RESET) begin
      r_state <= S_CLEAR;
      r_cnt   <= '0;
      r_q     <= '0;
      r_qv    <= 1'b0;
      r_rdy   <= 1'b0;
    end else begin
      r_qv <= 1'b0;
      case (r_state)
        S_CLEAR: begin
          r_rdy <= 1'b0;
          if (r_cnt == LP_LAST) begin
            r_state <= S_IDLE;
            r_rdy   <= 1'b1;
            r_cnt   <= '0;
          end else begin
            r_cnt <= r_cnt + ADD_WIDTH'(1);
          end
        end
        S_IDLE: begin
          r_rdy <= 1'b1;
          if (w_rd) begin
            r_qv <= 1'b1;
            // Out-of-range reads complete normally but return zero.
            r_q  <= w_addr_ok ? r_mem[bus.A] : '0;
          end
        end
        default: begin
          r_state <= S_CLEAR;
          r_cnt   <= '0;
          r_rdy   <= 1'b0;
        end
      endcase
    end
  end

  // Storage array: zero sweep while clearing, byte-masked writes when idle.
  always_ff @(posedge CLK) begin
    if (r_state == S_CLEAR) begin
      r_mem[r_cnt] <= '0;
    end else if (w_wr) begin
      for (int i = 0; i < NBYTES; i++) begin
        if (bus.M[i]) begin
          r_mem[bus.A][8*i +: 8] <= bus.D[8*i +: 8];
        end
      end
    end
  end

`ifdef SRAM_CLR_OUTREG_EN
  logic [WIDTH-1:0] r_q2;
  logic             r_qv2;

  // Extra output stage; captures only on a completing read so Q holds.
  always_ff @(posedge CLK) begin
    if (RESET) begin
      r_q2  <= '0;
      r_qv2 <= 1'b0;
    end else begin
      r_qv2 <= r_qv;
      if (r_qv) begin
        r_q2 <= r_q;
      end
    end
  end

  assign bus.Q  = r_q2;
  assign bus.QV = r_qv2;
`else
  assign bus.Q  = r_q;
  assign bus.QV = r_qv;
`endif

  assign bus.RDY = r_rdy;

endmodule

// File: tb/tb_sram_clr.sv
// tb_sram_clr -- self-checking bench for sram_clr (SIZE=16, WIDTH=32).
// Reads push {expected data, due cycle} onto a scoreboard; a negedge
// monitor pops on every QV and checks data and exact latency.
module tb_sram_clr;
  localparam int SIZE = 16;
  localparam int WIDTH = 32;
  localparam int AW = 4;
`ifdef SRAM_CLR_OUTREG_EN
  localparam int LAT = 2;
`else
  localparam int LAT = 1;
`endif

  typedef struct {
    logic [31:0] data;
    int          due;
  } exp_t;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  int          cyc = 0;
  int          n_checks = 0;
  int          n_fail = 0;
  logic [31:0] last_q = 32'h0;
  logic [31:0] model [SIZE];
  exp_t        sb [$];

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  sram_clr_if #(.WIDTH(WIDTH), .ADD_WIDTH(AW)) bus ();

  sram_clr #(.SIZE(SIZE), .WIDTH(WIDTH), .ADD_WIDTH(AW)) dut (
    .CLK   (clk),
    .RESET (rst),
    .bus   (bus)
  );

  // Scoreboard monitor: every QV must match the oldest outstanding read.
  always @(negedge clk) begin
    exp_t e;
    if (bus.QV === 1'b1) begin
      n_checks++;
      if (sb.size() == 0) begin
        n_fail++;
        $display("FAIL qv_unexpected: QV=1 Q=%h at cycle %0d, required no read pending", bus.Q, cyc);
      end else begin
        e = sb.pop_front();
        if (bus.Q !== e.data || cyc != e.due) begin
          n_fail++;
          $display("FAIL read_data: Q=%h at cycle %0d, required Q=%h at cycle %0d", bus.Q, cyc, e.data, e.due);
        end
        last_q = e.data;
      end
    end else if (sb.size() > 0 && sb[0].due < cyc) begin
      n_checks++;
      n_fail++;
      e = sb.pop_front();
      $display("FAIL read_missing: QV=%b at cycle %0d, required Q=%h by cycle %0d", bus.QV, cyc, e.data, e.due);
    end
  end

  // Applies inputs for the next rising edge and returns at the following negedge.
  task automatic drive(input logic cen, input logic wen, input logic [AW-1:0] a,
                       input logic [31:0] d, input logic [3:0] m);
    bus.CEN = cen;
    bus.WEN = wen;
    bus.A   = a;
    bus.D   = d;
    bus.M   = m;
    @(negedge clk);
  endtask

  task automatic idle();
    drive(1'b1, 1'b1, 4'h0, 32'h0, 4'h0);
  endtask

  task automatic wr(input logic [AW-1:0] a, input logic [31:0] d, input logic [3:0] m);
    for (int i = 0; i < 4; i++) begin
      if (m[i]) model[a][8*i +: 8] = d[8*i +: 8];
    end
    drive(1'b0, 1'b0, a, d, m);
  endtask

  task automatic do_read(input logic [AW-1:0] a);
    exp_t e;
    e.data = model[a];
    e.due  = cyc + LAT;
    sb.push_back(e);
    drive(1'b0, 1'b1, a, 32'h0, 4'h0);
  endtask

  task automatic drain();
    for (int i = 0; i < 10 && sb.size() != 0; i++) idle();
    n_checks++;
    if (sb.size() != 0) begin
      n_fail++;
      $display("FAIL drain_timeout: %0d reads outstanding, required 0", sb.size());
      sb.delete();
    end
  endtask

  task automatic clear_model();
    for (int i = 0; i < SIZE; i++) model[i] = 32'h0;
  endtask

  // Counts RDY=0 cycles after a reset edge, then expects RDY=1.
  task automatic check_clear_sweep(input string tag);
    for (int i = 1; i <= 15; i++) begin
      idle();
      n_checks++;
      if (bus.RDY !== 1'b0 || bus.QV !== 1'b0) begin
        n_fail++;
        $display("FAIL %s_clear_rdy: cycle %0d RDY=%b QV=%b, required RDY=0 QV=0", tag, i, bus.RDY, bus.QV);
      end
    end
    idle();
    n_checks++;
    if (bus.RDY !== 1'b1) begin
      n_fail++;
      $display("FAIL %s_rdy_rise: RDY=%b after 16 clear cycles, required 1", tag, bus.RDY);
    end
    clear_model();
  endtask

  task automatic test_reset();
    rst = 1'b1;
    drive(1'b0, 1'b1, 4'h2, 32'h0, 4'h0);
    rst = 1'b0;
    n_checks++;
    if (bus.RDY !== 1'b0 || bus.QV !== 1'b0 || bus.Q !== 32'h0) begin
      n_fail++;
      $display("FAIL reset_state: RDY=%b QV=%b Q=%h, required 0 0 00000000", bus.RDY, bus.QV, bus.Q);
    end
    // Requests during the sweep must be ignored (write to A=5, read A=2).
    for (int i = 1; i <= 15; i++) begin
      if (i == 4 || i == 12) drive(1'b0, 1'b0, 4'h5, 32'hFFFFFFFF, 4'hF);
      else if (i == 7) drive(1'b0, 1'b1, 4'h2, 32'h0, 4'h0);
      else idle();
      n_checks++;
      if (bus.RDY !== 1'b0 || bus.QV !== 1'b0 || bus.Q !== 32'h0) begin
        n_fail++;
        $display("FAIL clear_ignore: cycle %0d RDY=%b QV=%b Q=%h, required 0 0 00000000", i, bus.RDY, bus.QV, bus.Q);
      end
    end
    idle();
    n_checks++;
    if (bus.RDY !== 1'b1) begin
      n_fail++;
      $display("FAIL rdy_rise: RDY=%b at cycle 17, required 1", bus.RDY);
    end
    clear_model();
  endtask

  task automatic test_clear_zero();
    for (int a = 0; a < SIZE; a++) do_read(AW'(a));
    drain();
  endtask

  task automatic test_write_read();
    wr(4'h3, 32'hDEADBEEF, 4'hF);
    do_read(4'h3);
    drain();
    n_checks++;
    if (last_q !== 32'hDEADBEEF) begin
      n_fail++;
      $display("FAIL write_read: Q=%h, required DEADBEEF", last_q);
    end
  endtask

  task automatic test_byte_mask();
    wr(4'h3, 32'h11223344, 4'h5);
    do_read(4'h3);
    wr(4'h3, 32'hFFFFFFFF, 4'h0);
    do_read(4'h3);
    drain();
    n_checks++;
    if (last_q !== 32'hDE22BE44) begin
      n_fail++;
      $display("FAIL byte_mask: Q=%h, required DE22BE44", last_q);
    end
  endtask

  task automatic test_cen_hold();
    for (int i = 0; i < 4; i++) begin
      drive(1'b1, 1'b0, 4'h3, $urandom, 4'hF);
      n_checks++;
      if (bus.QV !== 1'b0 || bus.Q !== last_q) begin
        n_fail++;
        $display("FAIL cen_hold: QV=%b Q=%h, required QV=0 Q=%h", bus.QV, bus.Q, last_q);
      end
    end
    do_read(4'h3);
    drain();
  endtask

  task automatic test_back_to_back();
    wr(4'h1, 32'h000000A1, 4'hF);
    wr(4'h2, 32'h000000A2, 4'hF);
    wr(4'h3, 32'h000000A3, 4'hF);
    do_read(4'h1);
    do_read(4'h2);
    do_read(4'h3);
    wr(4'hF, 32'hCAFEF00D, 4'hF);
    do_read(4'hF);
    do_read(4'h0);
    drain();
  endtask

  task automatic test_reset_mid_read();
`ifdef SRAM_CLR_OUTREG_EN
    drive(1'b0, 1'b1, 4'h3, 32'h0, 4'h0);
`else
    do_read(4'h3);
`endif
    rst = 1'b1;
    idle();
    rst = 1'b0;
    n_checks++;
    if (bus.QV !== 1'b0 || bus.Q !== 32'h0 || bus.RDY !== 1'b0) begin
      n_fail++;
      $display("FAIL reset_mid_read: QV=%b Q=%h RDY=%b, required 0 00000000 0", bus.QV, bus.Q, bus.RDY);
    end
    check_clear_sweep("first");
  endtask

  task automatic test_reset_mid_clear();
    wr(4'h7, 32'h12345678, 4'hF);
    rst = 1'b1;
    idle();
    rst = 1'b0;
    for (int i = 0; i < 5; i++) idle();
    rst = 1'b1;
    idle();
    rst = 1'b0;
    n_checks++;
    if (bus.RDY !== 1'b0) begin
      n_fail++;
      $display("FAIL reset_mid_clear: RDY=%b, required 0", bus.RDY);
    end
    check_clear_sweep("restart");
    do_read(4'h7);
    do_read(4'h3);
    drain();
  endtask

  initial begin
    bus.CEN = 1'b1;
    bus.WEN = 1'b1;
    bus.A   = 4'h0;
    bus.D   = 32'h0;
    bus.M   = 4'h0;
    @(negedge clk);
    test_reset();
    test_clear_zero();
    test_write_read();
    test_byte_mask();
    test_cen_hold();
    test_back_to_back();
    test_reset_mid_read();
    test_reset_mid_clear();
    drain();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, required finish before 200000");
    $fatal(1, "watchdog");
  end

endmodule
